mac_unit: RTL and testbench

- Sequential multiply-accumulate engine for a memory-mapped peripheral.
- Each 32-bit operand word packs four 8-bit lanes. On a start command the block computes a dot product of the selected lanes, one multiply per clock, and accumulates into a 16-bit result.
- Raises a one-cycle interrupt pulse on completion.

---
 rtl/mac_unit_if.sv | 28 ++
 rtl/mac_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mac_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mac_unit_if.sv
// Register-side bus of the multiply-accumulate peripheral: operand words, control word,
// result and completion interrupt.
interface mac_unit_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 16
);
    logic [8*LANES-1:0] MAC_INA;
    logic [8*LANES-1:0] MAC_INB;
    logic [7:0]         MAC_CTRL;
    logic [ACC_W-1:0]   MAC_OUT;
    logic               IRQ_MAC;

    modport master (
        output MAC_INA,
        output MAC_INB,
        output MAC_CTRL,
        input  MAC_OUT,
        input  IRQ_MAC
    );

    modport slave (
        input  MAC_INA,
        input  MAC_INB,
        input  MAC_CTRL,
        output MAC_OUT,
        output IRQ_MAC
    );
endinterface

// File: rtl/mac_unit.sv
// Sequential lane-wise 8x8 dot-product engine: one multiply per clock into a 16-bit accumulator,
// one-cycle IRQ on completion. Define MAC_SAT_EN to clamp after every step instead of wrapping.
module mac_unit #(
    parameter int LANES = 4,
    parameter int ACC_W = 16
) (
    input  logic      clk,
    input  logic      reset,
    mac_unit_if.slave bus
);
    localparam int OPW   = 8 * LANES;
    localparam int SUM_W = ACC_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [OPW-1:0]     a_r;
    logic [OPW-1:0]     b_r;
    logic [1:0]         lane_cnt_r;
    logic               signed_r;
    logic               irq_en_r;
    logic [ACC_W-1:0]   acc_r;
    logic [1:0]         lane_idx_r;
    logic               start_prev_r;
    logic [ACC_W-1:0]   mac_out_r;
    logic               irq_r;

    logic [OPW-1:0]     a_nxt_s;
    logic [OPW-1:0]     b_nxt_s;
    logic [1:0]         lane_cnt_nxt_s;
    logic               signed_nxt_s;
    logic               irq_en_nxt_s;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [1:0]         lane_idx_nxt_s;
    logic [ACC_W-1:0]   mac_out_nxt_s;
    logic               irq_nxt_s;

    logic               en_s;
    logic               start_s;
    logic [1:0]         last_lane_s;
    logic [7:0]         a_lane_s;
    logic [7:0]         b_lane_s;
    logic signed [SUM_W-1:0] a_ext_s;
    logic signed [SUM_W-1:0] b_ext_s;
    logic signed [SUM_W-1:0] prod_s;
    logic signed [SUM_W-1:0] acc_ext_s;
    logic signed [SUM_W-1:0] sum_s;
    logic [ACC_W-1:0]   acc_step_s;
    logic               ctrl_unused_s;

    // Clamp a widened sum into the signed or unsigned accumulator range.
    function automatic logic [ACC_W-1:0] clamp_acc(input logic signed [SUM_W-1:0] sum,
                                                   input logic is_signed);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        if (is_signed) begin
            hi = {2'b00, 1'b0, {(ACC_W-1){1'b1}}};
            lo = {2'b11, 1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            hi = {2'b00, {ACC_W{1'b1}}};
            lo = {SUM_W{1'b0}};
        end
        if (sum > hi) begin
            clamp_acc = hi[ACC_W-1:0];
        end else if (sum < lo) begin
            clamp_acc = lo[ACC_W-1:0];
        end else begin
            clamp_acc = sum[ACC_W-1:0];
        end
    endfunction

    assign en_s          = bus.MAC_CTRL[7];
    assign ctrl_unused_s = bus.MAC_CTRL[6];
    assign start_s       = bus.MAC_CTRL[1] & ~start_prev_r & en_s & (state_r == ST_IDLE);

    // Lane-count code 00 means all four lanes, so the last index is simply code-1 modulo 4.
    assign last_lane_s = lane_cnt_r - 2'd1;

    assign a_lane_s  = a_r[{lane_idx_r, 3'b000} +: 8];
    assign b_lane_s  = b_r[{lane_idx_r, 3'b000} +: 8];
    assign a_ext_s   = {{(SUM_W-8){signed_r & a_lane_s[7]}}, a_lane_s};
    assign b_ext_s   = {{(SUM_W-8){signed_r & b_lane_s[7]}}, b_lane_s};
    assign prod_s    = a_ext_s * b_ext_s;
    assign acc_ext_s = {{(SUM_W-ACC_W){signed_r & acc_r[ACC_W-1]}}, acc_r};
    assign sum_s     = acc_ext_s + prod_s;

`ifdef MAC_SAT_EN
    assign acc_step_s = clamp_acc(sum_s, signed_r);
`else
    logic [SUM_W-ACC_W-1:0] sum_unused_s;
    assign sum_unused_s = sum_s[SUM_W-1:ACC_W];
    assign acc_step_s   = sum_s[ACC_W-1:0];
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; dropping EN aborts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (!en_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (lane_idx_r == last_lane_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: next values for the operand latches, accumulator and outputs.
    always_comb begin
        a_nxt_s        = a_r;
        b_nxt_s        = b_r;
        lane_cnt_nxt_s = lane_cnt_r;
        signed_nxt_s   = signed_r;
        irq_en_nxt_s   = irq_en_r;
        acc_nxt_s      = acc_r;
        lane_idx_nxt_s = lane_idx_r;
        mac_out_nxt_s  = mac_out_r;
        irq_nxt_s      = 1'b0;
        if (!en_s) begin
            lane_idx_nxt_s = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        a_nxt_s        = bus.MAC_INA;
                        b_nxt_s        = bus.MAC_INB;
                        lane_cnt_nxt_s = bus.MAC_CTRL[5:4];
                        signed_nxt_s   = bus.MAC_CTRL[3];
                        irq_en_nxt_s   = bus.MAC_CTRL[0];
                        acc_nxt_s      = bus.MAC_CTRL[2] ? mac_out_r : {ACC_W{1'b0}};
                        lane_idx_nxt_s = 2'd0;
                    end else begin
                        lane_idx_nxt_s = lane_idx_r;
                    end
                end
                ST_RUN: begin
                    acc_nxt_s      = acc_step_s;
                    lane_idx_nxt_s = lane_idx_r + 2'd1;
                end
                ST_DONE: begin
                    mac_out_nxt_s = acc_r;
                    irq_nxt_s     = irq_en_r;
                end
                default: begin
                    lane_idx_nxt_s = 2'd0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r          <= {OPW{1'b0}};
            b_r          <= {OPW{1'b0}};
            lane_cnt_r   <= 2'd0;
            signed_r     <= 1'b0;
            irq_en_r     <= 1'b0;
            acc_r        <= {ACC_W{1'b0}};
            lane_idx_r   <= 2'd0;
            start_prev_r <= 1'b0;
            mac_out_r    <= {ACC_W{1'b0}};
            irq_r        <= 1'b0;
        end else begin
            a_r          <= a_nxt_s;
            b_r          <= b_nxt_s;
            lane_cnt_r   <= lane_cnt_nxt_s;
            signed_r     <= signed_nxt_s;
            irq_en_r     <= irq_en_nxt_s;
            acc_r        <= acc_nxt_s;
            lane_idx_r   <= lane_idx_nxt_s;
            start_prev_r <= bus.MAC_CTRL[1];
            mac_out_r    <= mac_out_nxt_s;
            irq_r        <= irq_nxt_s;
        end
    end

    assign bus.MAC_OUT = mac_out_r;
    assign bus.IRQ_MAC = irq_r;
endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: a table of hand-computed dot products plus sequences for
// reset, re-triggered START, EN abort and asynchronous reset during an operation.
module tb_mac_unit;
    logic clk;
    logic reset;

    mac_unit_if bus ();

    mac_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ina;
        logic [31:0] inb;
        logic [7:0]  ctrl;
        int          lanes;
        logic [15:0] exp_out;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs [9];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_out;
    int          hits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic count_irq(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.IRQ_MAC === 1'b1) n++;
        end
    endtask

    task automatic run_op(input vec_t v, input logic [15:0] prev, input int idx);
        @(negedge clk);
        bus.MAC_INA  = v.ina;
        bus.MAC_INB  = v.inb;
        bus.MAC_CTRL = v.ctrl & 8'hFD;
        @(negedge clk);
        bus.MAC_CTRL = v.ctrl | 8'h02;
        @(negedge clk);
        // Disturb operands and non-EN/START fields after the start edge.
        bus.MAC_INA  = ~v.ina;
        bus.MAC_INB  = 32'h5A5A5A5A;
        bus.MAC_CTRL = (v.ctrl | 8'h02) ^ 8'h3D;
        check($sformatf("v%0d_irq_e0", idx), {31'd0, bus.IRQ_MAC}, 32'd0);
        for (int k = 1; k <= v.lanes; k++) begin
            @(negedge clk);
            check($sformatf("v%0d_irq_e%0d", idx, k), {31'd0, bus.IRQ_MAC}, 32'd0);
            check($sformatf("v%0d_hold_e%0d", idx, k), {16'd0, bus.MAC_OUT}, {16'd0, prev});
        end
        @(negedge clk);
        check($sformatf("v%0d_out", idx), {16'd0, bus.MAC_OUT}, {16'd0, v.exp_out});
        check($sformatf("v%0d_irq", idx), {31'd0, bus.IRQ_MAC}, {31'd0, v.exp_irq});
        @(negedge clk);
        check($sformatf("v%0d_irq_end", idx), {31'd0, bus.IRQ_MAC}, 32'd0);
        check($sformatf("v%0d_out_stable", idx), {16'd0, bus.MAC_OUT}, {16'd0, v.exp_out});
    endtask

    initial begin
        vecs[0] = '{32'h04030201, 32'h08070605, 8'h81, 4, 16'h0046, 1'b1};
        vecs[1] = '{32'h04030201, 32'h08070605, 8'h8D, 4, 16'h008C, 1'b1};
        vecs[2] = '{32'h000000FF, 32'h00000002, 8'h99, 1, 16'hFFFE, 1'b1};
`ifdef MAC_SAT_EN
        vecs[3] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 8'h89, 4, 16'h7FFF, 1'b1};
        vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 8'hA1, 2, 16'hFFFF, 1'b1};
`else
        vecs[3] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 8'h89, 4, 16'hFC04, 1'b1};
        vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 8'hA1, 2, 16'hFC02, 1'b1};
`endif
        vecs[5] = '{32'h11223344, 32'h01010101, 8'hB0, 3, 16'h0099, 1'b0};
        vecs[6] = '{32'h80FF7F01, 32'h7F02FF80, 8'h89, 4, 16'hBF7F, 1'b1};
        vecs[7] = '{32'h00000001, 32'h00000001, 8'h95, 1, 16'hBF80, 1'b1};
`ifdef MAC_SAT_EN
        vecs[8] = '{32'h80808080, 32'h7F7F7F7F, 8'h8D, 4, 16'h8000, 1'b1};
`else
        vecs[8] = '{32'h80808080, 32'h7F7F7F7F, 8'h8D, 4, 16'hC180, 1'b1};
`endif

        // Reset with EN set and no start.
        reset        = 1'b0;
        bus.MAC_INA  = 32'h0;
        bus.MAC_INB  = 32'h0;
        bus.MAC_CTRL = 8'h80;
        #2;
        check("rst_out", {16'd0, bus.MAC_OUT}, 32'd0);
        check("rst_irq", {31'd0, bus.IRQ_MAC}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        count_irq(3, hits);
        check("idle_irq_count", hits, 32'd0);
        check("idle_out", {16'd0, bus.MAC_OUT}, 32'd0);

        model_out = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], model_out, i);
            model_out = vecs[i].exp_out;
        end

        // START held high after DONE: no further operation or pulse.
        count_irq(6, hits);
        check("held_start_irq_count", hits, 32'd0);
        check("held_start_out", {16'd0, bus.MAC_OUT}, {16'd0, model_out});

        // Second START edge during RUN is ignored and not queued.
        @(negedge clk);
        bus.MAC_INA  = 32'h04030201;
        bus.MAC_INB  = 32'h08070605;
        bus.MAC_CTRL = 8'h81;
        @(negedge clk);
        bus.MAC_CTRL = 8'h83;
        @(negedge clk);
        bus.MAC_CTRL = 8'h81;
        @(negedge clk);
        bus.MAC_CTRL = 8'h83;
        count_irq(3, hits);
        check("retrig_early_irq", hits, 32'd0);
        check("retrig_hold", {16'd0, bus.MAC_OUT}, {16'd0, model_out});
        @(negedge clk);
        check("retrig_out", {16'd0, bus.MAC_OUT}, 32'h0046);
        check("retrig_irq", {31'd0, bus.IRQ_MAC}, 32'd1);
        model_out = 16'h0046;
        count_irq(10, hits);
        check("retrig_no_second_irq", hits, 32'd0);
        check("retrig_out_stable", {16'd0, bus.MAC_OUT}, 32'h0046);

        // EN dropped mid-RUN aborts with no IRQ and MAC_OUT retained.
        @(negedge clk);
        bus.MAC_INA  = 32'h01010101;
        bus.MAC_INB  = 32'h01010101;
        bus.MAC_CTRL = 8'h81;
        @(negedge clk);
        bus.MAC_CTRL = 8'h83;
        @(negedge clk);
        @(negedge clk);
        bus.MAC_CTRL = 8'h03;
        count_irq(8, hits);
        check("abort_irq_count", hits, 32'd0);
        check("abort_out", {16'd0, bus.MAC_OUT}, {16'd0, model_out});
        bus.MAC_CTRL = 8'h83;
        count_irq(8, hits);
        check("abort_reenable_irq", hits, 32'd0);
        check("abort_reenable_out", {16'd0, bus.MAC_OUT}, {16'd0, model_out});

        // Asynchronous reset mid-RUN clears outputs immediately.
        @(negedge clk);
        bus.MAC_CTRL = 8'h81;
        @(negedge clk);
        bus.MAC_CTRL = 8'h83;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", {16'd0, bus.MAC_OUT}, 32'd0);
        check("async_rst_irq", {31'd0, bus.IRQ_MAC}, 32'd0);
        @(negedge clk);
        bus.MAC_CTRL = 8'h80;
        @(negedge clk);
        reset = 1'b1;
        count_irq(8, hits);
        check("post_rst_irq_count", hits, 32'd0);
        check("post_rst_out", {16'd0, bus.MAC_OUT}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
